// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: multiply/divide issue controller at the E/M boundary.
// Captures E-stage HI/LO instructions and drives one-cycle registered
// Start/LOWrite/HIWrite pulses with latched operands. It tracks the unit's
// Busy window and stalls D while a HI/LO operation is in flight.
// Optional feature: define MD_WATCHDOG_EN to enable the busy watchdog and the
// sticky protocol error flag (md_err).
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | no operation in flight; accepts mtlo/mthi/start from E
//  ST_ISSUE | md_start is high this cycle; Busy not yet visible
//  ST_WAIT  | unit is working; leave when md_busy drops (or watchdog fires)
module md_issue_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int OPW      = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           D_md_use,
   input  logic           E_valid,
   input  logic           E_start,
   input  logic           E_mtlo,
   input  logic           E_mthi,
   input  logic [OPW-1:0] E_aluop,
   input  logic [31:0]    E_rs,
   input  logic [31:0]    E_rt,
   input  logic           md_busy,
   output logic           md_start,
   output logic           md_lowrite,
   output logic           md_hiwrite,
   output logic [OPW-1:0] md_aluop,
   output logic [31:0]    md_d1,
   output logic [31:0]    md_d2,
   output logic           stall,
   output logic           md_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_start;
   logic             r_lowrite;
   logic             r_hiwrite;
   logic [OPW-1:0]   r_aluop;
   logic [31:0]      r_d1;
   logic [31:0]      r_d2;
   logic             w_req;

`ifdef MD_WATCHDOG_EN
   localparam logic [4:0] LP_MAX_WAIT = 5'(MAX_WAIT);
   logic [4:0]       r_wcnt;
   logic             r_err;
`else
   // MAX_WAIT only matters to the watchdog; keep it referenced in this build.
   logic             w_unused_cfg;
   assign w_unused_cfg = (MAX_WAIT != 0);
`endif

   // Any HI/LO request presented by a valid E-stage instruction.
   assign w_req = E_valid & (E_mtlo | E_mthi | E_start);

   // Issue FSM: registered command pulses, operand latch and Busy tracking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_start   <= 1'b0;
         r_lowrite <= 1'b0;
         r_hiwrite <= 1'b0;
         r_aluop   <= '0;
         r_d1      <= '0;
         r_d2      <= '0;
`ifdef MD_WATCHDOG_EN
         r_wcnt    <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_start   <= 1'b0;
         r_lowrite <= 1'b0;
         r_hiwrite <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // mtlo wins over mthi, which wins over start: one pulse per cycle.
               if (E_valid & E_mtlo) begin
                  r_lowrite <= 1'b1;
                  r_aluop   <= E_aluop;
                  r_d1      <= E_rs;
                  r_d2      <= E_rt;
               end else if (E_valid & E_mthi) begin
                  r_hiwrite <= 1'b1;
                  r_aluop   <= E_aluop;
                  r_d1      <= E_rs;
                  r_d2      <= E_rt;
               end else if (E_valid & E_start) begin
                  r_start   <= 1'b1;
                  r_aluop   <= E_aluop;
                  r_d1      <= E_rs;
                  r_d2      <= E_rt;
                  r_state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_WAIT;
`ifdef MD_WATCHDOG_EN
               r_wcnt  <= '0;
               if (w_req) r_err <= 1'b1;
`endif
            end
            ST_WAIT: begin
`ifdef MD_WATCHDOG_EN
               if (w_req) r_err <= 1'b1;
               if (md_busy && (r_wcnt == LP_MAX_WAIT)) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (md_busy) begin
                  if (r_wcnt != 5'h1f) r_wcnt <= r_wcnt + 5'd1;
               end else begin
                  r_state <= ST_IDLE;
               end
`else
               // An illegal op never raises Busy, so this also exits after one cycle.
               if (!md_busy) r_state <= ST_IDLE;
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Stall also covers the E_start cycle, before Start is registered.
   assign stall = D_md_use & ((r_state != ST_IDLE) | (E_valid & E_start));

   assign md_start   = r_start;
   assign md_lowrite = r_lowrite;
   assign md_hiwrite = r_hiwrite;
   assign md_aluop   = r_aluop;
   assign md_d1      = r_d1;
   assign md_d2      = r_d2;
`ifdef MD_WATCHDOG_EN
   assign md_err     = r_err;
`else
   assign md_err     = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural mult/div unit.
// Unit model: Busy rises in the Start cycle and stays up for 5 (mult) or
// 10 (div) cycles; HI/LO results are computed when Start is seen.
module tb_md_issue_ctrl;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MD_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        D_md_use;
   logic        E_valid;
   logic        E_start;
   logic        E_mtlo;
   logic        E_mthi;
   logic [3:0]  E_aluop;
   logic [31:0] E_rs;
   logic [31:0] E_rt;
   logic        md_busy;
   logic        md_start;
   logic        md_lowrite;
   logic        md_hiwrite;
   logic [3:0]  md_aluop;
   logic [31:0] md_d1;
   logic [31:0] md_d2;
   logic        stall;
   logic        md_err;

   logic        busy_force;
   logic [3:0]  r_ucnt;
   logic [31:0] r_lo;
   logic [31:0] r_hi;

   int n_cmp;
   int n_mis;

   md_issue_ctrl #(.MAX_WAIT(16), .OPW(4)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .D_md_use   (D_md_use),
      .E_valid    (E_valid),
      .E_start    (E_start),
      .E_mtlo     (E_mtlo),
      .E_mthi     (E_mthi),
      .E_aluop    (E_aluop),
      .E_rs       (E_rs),
      .E_rt       (E_rt),
      .md_busy    (md_busy),
      .md_start   (md_start),
      .md_lowrite (md_lowrite),
      .md_hiwrite (md_hiwrite),
      .md_aluop   (md_aluop),
      .md_d1      (md_d1),
      .md_d2      (md_d2),
      .stall      (stall),
      .md_err     (md_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] unit_res(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_MULT:  return 64'(sa * sb);
         OP_MULTU: return {32'd0, a} * {32'd0, b};
         OP_DIV:   return (b == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
         OP_DIVU:  return (b == 0) ? 64'd0 : {a % b, a / b};
         default:  return 64'd0;
      endcase
   endfunction

   // Behavioural mult/div unit.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ucnt <= '0;
         r_lo   <= '0;
         r_hi   <= '0;
      end else begin
         if (md_start) begin
            r_ucnt <= ((md_aluop == OP_MULT) || (md_aluop == OP_MULTU)) ? 4'd4 : 4'd9;
            {r_hi, r_lo} <= unit_res(md_aluop, md_d1, md_d2);
         end else if (r_ucnt != 0) begin
            r_ucnt <= r_ucnt - 4'd1;
         end
         if (md_lowrite) r_lo <= md_d1;
         if (md_hiwrite) r_hi <= md_d1;
      end
   end

   assign md_busy = md_start | (r_ucnt != 0) | busy_force;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_e;
      E_valid = 1'b0;
      E_start = 1'b0;
      E_mtlo  = 1'b0;
      E_mthi  = 1'b0;
   endtask

   // Present one start in E, then count stall and Start cycles until stall drops.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n_stall, output int n_start);
      tick;
      E_valid = 1'b1; E_start = 1'b1; E_aluop = op; E_rs = a; E_rt = b;
      #1;
      n_stall = 0;
      n_start = 0;
      for (int c = 0; c < 60; c++) begin
         if (!stall) break;
         n_stall++;
         if (md_start) n_start++;
         tick;
         clear_e();
         #1;
      end
   endtask

   int ns, nst;

   initial begin
      n_cmp = 0;
      n_mis = 0;
      busy_force = 1'b0;
      reset = 1'b0;
      D_md_use = 1'b0;
      clear_e();
      E_aluop = '0; E_rs = '0; E_rt = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_start", md_start, 0);
      check_val("rst_lowrite", md_lowrite, 0);
      check_val("rst_hiwrite", md_hiwrite, 0);
      check_val("rst_d1", md_d1, 0);
      check_val("rst_d2", md_d2, 0);
      check_val("rst_aluop", md_aluop, 0);
      check_val("rst_err", md_err, 0);
      @(negedge clk);
      reset = 1'b1;

      // 1: mult 7 * -3 with D_md_use held.
      D_md_use = 1'b1;
      run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, ns, nst);
      check_val("mult_stall_cycles", ns, 7);
      check_val("mult_start_pulses", nst, 1);
      check_val("mult_d1", md_d1, 32'd7);
      check_val("mult_d2", md_d2, 32'hFFFF_FFFD);
      check_val("mult_aluop", md_aluop, OP_MULT);
      check_val("mult_lo", r_lo, 32'hFFFF_FFEB);
      check_val("mult_hi", r_hi, 32'hFFFF_FFFF);

      // 2: divu 100 / 7.
      run_op(OP_DIVU, 32'd100, 32'd7, ns, nst);
      check_val("divu_stall_cycles", ns, 12);
      check_val("divu_start_pulses", nst, 1);
      check_val("divu_lo", r_lo, 32'd14);
      check_val("divu_hi", r_hi, 32'd2);
      check_val("divu_err", md_err, 0);

      // 3: mtlo, mthi and start together: only LOWrite fires.
      tick;
      E_valid = 1'b1; E_mtlo = 1'b1; E_mthi = 1'b1; E_start = 1'b1;
      E_aluop = OP_MULT; E_rs = 32'h55; E_rt = 32'h77;
      #1;
      check_val("prio_req_stall", stall, 1);
      tick;
      clear_e();
      #1;
      check_val("prio_lowrite", md_lowrite, 1);
      check_val("prio_hiwrite", md_hiwrite, 0);
      check_val("prio_start", md_start, 0);
      check_val("prio_d1", md_d1, 32'h55);
      check_val("prio_idle_stall", stall, 0);
      tick;
      check_val("prio_lowrite_pulse", md_lowrite, 0);
      check_val("prio_lo", r_lo, 32'h55);

      // mthi alone.
      E_valid = 1'b1; E_mthi = 1'b1; E_rs = 32'hA5A5;
      #1;
      check_val("mthi_no_stall", stall, 0);
      tick;
      clear_e();
      #1;
      check_val("mthi_hiwrite", md_hiwrite, 1);
      check_val("mthi_lowrite", md_lowrite, 0);
      check_val("mthi_d1", md_d1, 32'hA5A5);
      tick;
      check_val("mthi_hiwrite_pulse", md_hiwrite, 0);
      check_val("mthi_hi", r_hi, 32'hA5A5);

      // Bubble carrying a start: ignored.
      E_valid = 1'b0; E_start = 1'b1; E_rs = 32'h1234;
      #1;
      check_val("bubble_stall", stall, 0);
      tick;
      clear_e();
      #1;
      check_val("bubble_start", md_start, 0);
      check_val("bubble_d1", md_d1, 32'hA5A5);

      // 4: mult then mflo in D: continuous stall, no gap.
      run_op(OP_MULT, 32'd9, 32'd9, ns, nst);
      check_val("b2b_stall_cycles", ns, 7);
      check_val("b2b_lo", r_lo, 32'd81);

      // 5: reset mid-WAIT of a div (cycle 4 after E_start).
      tick;
      E_valid = 1'b1; E_start = 1'b1; E_aluop = OP_DIVU; E_rs = 32'd100; E_rt = 32'd7;
      tick;
      clear_e();
      repeat (3) tick;
      #3;
      check_val("midrst_pre_stall", stall, 1);
      reset = 1'b0;
      #1;
      check_val("midrst_stall", stall, 0);
      check_val("midrst_d1", md_d1, 0);
      check_val("midrst_d2", md_d2, 0);
      check_val("midrst_aluop", md_aluop, 0);
      check_val("midrst_start", md_start, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick;
      check_val("midrst_idle_stall", stall, 0);
      check_val("midrst_busy", md_busy, 0);
      run_op(OP_MULT, 32'd3, 32'd4, ns, nst);
      check_val("postrst_stall_cycles", ns, 7);
      check_val("postrst_lo", r_lo, 32'd12);

      // 6: Busy stuck high. Watchdog fires at wcnt=16; otherwise wait until release.
      tick;
      E_valid = 1'b1; E_start = 1'b1; E_aluop = OP_MULT; E_rs = 32'd2; E_rt = 32'd2;
      busy_force = 1'b1;
      #1;
      ns = 0;
      for (int c = 0; c < 60; c++) begin
         if (c == 21) busy_force = 1'b0;
         if (!stall) break;
         ns++;
         tick;
         clear_e();
         #1;
      end
      busy_force = 1'b0;
      check_val("stuck_stall_cycles", ns, WD ? 19 : 22);
      check_val("stuck_err", md_err, WD);
      repeat (5) tick;
      check_val("stuck_err_hold", md_err, WD);
      check_val("stuck_idle_stall", stall, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_val("stuck_err_cleared", md_err, 0);
      @(negedge clk);
      reset = 1'b1;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
